periph_bus_bridge: RTL
======================

Name: periph_bus_bridge

Overview:
Single-outstanding bridge between the core's data-memory port and the memory-mapped peripherals (PLIC, GPIO, I2C, UART, TIMER).
- Consumes the one-hot select lines produced by the address decoder.
- Registers the request, drives one peripheral enable, and waits for that peripheral's ready.
- Returns read data and an error flag to the core.
- Converts decode faults and hung peripherals into a bus error instead of a stall.

Parameters:
NUM_SLV, 5, number of peripheral ports; bit order 0=PLIC, 1=GPIO, 2=I2C, 3=UART, 4=TIMER
TIMEOUT_CYC, 256, maximum ACCESS cycles before a timeout error (legal range 2..65535)
ERR_RDATA, 32'h0000_0000, read data returned with any error response

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
m_req  in  1  core request valid
m_ready  out  1  bridge can accept a request (high only in IDLE)
m_we  in  1  1=write, 0=read
m_addr  in  32  byte address
m_wdata  in  32  write data
m_wstrb  in  4  byte write strobes
m_rvalid  out  1  one-cycle response pulse, for reads and writes
m_rdata  out  32  read data, valid with m_rvalid
m_err  out  1  error flag, valid with m_rvalid
sel  in  NUM_SLV  one-hot selects from the address decoder, combinational on m_addr
s_en  out  NUM_SLV  per-peripheral access enable
s_we  out  1  registered write enable
s_addr  out  32  registered address
s_wdata  out  32  registered write data
s_wstrb  out  4  registered strobes
s_ready  in  NUM_SLV  per-peripheral access-complete flag
s_rdata  in  32*NUM_SLV  concatenated read data; slot i is bits [32i+31:32i]

Behaviour:
Reset values:
- m_ready=1; m_rvalid=0; m_err=0; m_rdata=0.
- s_en=0; s_we=0; s_addr=0; s_wdata=0; s_wstrb=0.
- FSM=IDLE; timeout counter=0.

FSM states: IDLE, ACCESS, RESP.

IDLE:
- m_ready=1.
- On m_req=1, latch m_addr, m_wdata, m_wstrb, m_we and sel into s_* and an internal sel_q.
- If sel is exactly one-hot, go to ACCESS.
- If sel is zero or has more than one bit set, go to RESP with err=1 (decode error; no s_en is ever asserted).

ACCESS:
- s_en = sel_q, held constant the whole time; s_* outputs are stable.
- Counter increments every cycle.
- If s_ready[idx]=1 (idx = the set bit of sel_q):
  - Capture s_rdata slot idx (captured for writes too, then forced to 0).
  - Set err=0 and go to RESP.
- Otherwise, if counter==TIMEOUT_CYC-1, set err=1, set rdata=ERR_RDATA, and go to RESP.
- If ready and timeout fall on the same cycle, ready wins (no error).
- s_ready bits for non-selected ports are ignored.

RESP:
- m_rvalid=1 for exactly one cycle.
- m_rdata = captured data for a successful read, 0 for a write, ERR_RDATA on error.
- m_err per the above.
- s_en=0.
- Counter clears; next state is IDLE.
- The core must accept the response; there is no back-pressure.

Latency (request accepted in cycle T):
- Fastest success: s_en high in T+1, s_ready in T+1, m_rvalid in T+2.
- Decode error: m_rvalid in T+1.
- Timeout: m_rvalid in T+1+TIMEOUT_CYC.

Other rules:
- m_ready is low in ACCESS and RESP; m_req during those states is ignored and must be held by the core.
- Back-to-back accesses are possible, one every 3 cycles minimum.
- Reset mid-access: s_en drops asynchronously, no response is issued, FSM returns to IDLE.

Optional Feature:
Macro PERIPH_BRIDGE_ERR_LOG_EN.
- When defined, adds three outputs:
  - err_addr (32): address of the most recent errored access, updated in the RESP cycle.
  - err_cause (2): 01=decode, 10=timeout.
  - err_cnt (8): saturating count of errors, sticks at 255.
- Adds one input, err_clr (1): clears all three to 0 on the next clock edge; err_clr has priority over a same-cycle error.
- All three outputs reset to 0.
- When the macro is undefined, these ports do not exist and bridge behaviour is otherwise identical.

Test Plan:
1. Read GPIO: addr=0x4000_0010, sel=5'b00010, s_ready[1] high on the first ACCESS cycle, slot1=0x1234_5678 -> s_en=5'b00010 for 1 cycle; m_rvalid at T+2; m_rdata=0x1234_5678; m_err=0.
2. Write UART with a 3-cycle wait: addr=0x6000_0000, wdata=0xA5, wstrb=4'b0001 -> s_en[3] held 3 cycles with s_addr/s_wdata stable; m_rvalid at T+4; m_rdata=0; m_err=0.
3. Decode hole: addr=0x7000_0000, sel=0 -> s_en never asserted; m_rvalid at T+1; m_err=1; m_rdata=ERR_RDATA.
4. Hung TIMER with TIMEOUT_CYC=8 and s_ready[4] never high -> s_en[4] high exactly 8 cycles; m_err=1 at T+9. With the macro defined: err_cause=2'b10, err_cnt=1.
5. Ready on the final timeout cycle (cycle 8 of 8) -> m_err=0 and the data is returned. A second request driven during RESP is not accepted until the next IDLE.
6. Assert rst during the 2nd ACCESS cycle -> s_en=0 immediately, m_rvalid never pulses, m_ready=1 after reset release; a following read completes normally.

Source files
------------

// File: rtl/periph_bus_bridge_if.sv
// periph_bus_bridge_if: core request/response and peripheral access bundle.
// slave = the bridge's view; master = the core and peripheral side.
interface periph_bus_bridge_if #(
  parameter int NUM_SLV = 5
);
  logic                   m_req;
  logic                   m_ready;
  logic                   m_we;
  logic [31:0]            m_addr;
  logic [31:0]            m_wdata;
  logic [3:0]             m_wstrb;
  logic                   m_rvalid;
  logic [31:0]            m_rdata;
  logic                   m_err;
  logic [NUM_SLV-1:0]     sel;
  logic [NUM_SLV-1:0]     s_en;
  logic                   s_we;
  logic [31:0]            s_addr;
  logic [31:0]            s_wdata;
  logic [3:0]             s_wstrb;
  logic [NUM_SLV-1:0]     s_ready;
  logic [32*NUM_SLV-1:0]  s_rdata;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, m_wstrb,
    input  sel, s_ready, s_rdata,
    output m_ready, m_rvalid, m_rdata, m_err,
    output s_en, s_we, s_addr, s_wdata, s_wstrb
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, m_wstrb,
    output sel, s_ready, s_rdata,
    input  m_ready, m_rvalid, m_rdata, m_err,
    input  s_en, s_we, s_addr, s_wdata, s_wstrb
  );
endinterface

// File: rtl/periph_bus_bridge.sv
// periph_bus_bridge: single-outstanding bridge from the core data port
// to PLIC/GPIO/I2C/UART/TIMER (sel bit 0..4). Decode faults and hung
// peripherals become a bus error response instead of a stall.
// Ports: clk, rst (async, active high); bus (slave modport) carries
// m_req/m_ready/m_we/m_addr/m_wdata/m_wstrb/m_rvalid/m_rdata/m_err,
// sel, s_en/s_we/s_addr/s_wdata/s_wstrb, s_ready, s_rdata.
// Option PERIPH_BRIDGE_ERR_LOG_EN adds err_clr, err_addr,
// err_cause (01 decode, 10 timeout) and saturating err_cnt.
module periph_bus_bridge #(
  parameter int          NUM_SLV     = 5,
  parameter int          TIMEOUT_CYC = 256,
  parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
`ifdef PERIPH_BRIDGE_ERR_LOG_EN
  input  logic        err_clr,
  output logic [31:0] err_addr,
  output logic [1:0]  err_cause,
  output logic [7:0]  err_cnt,
`endif
  periph_bus_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [NUM_SLV-1:0] r_sel;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wstrb;
  logic [15:0]        r_cnt;
  logic               r_err;
  logic [31:0]        r_rdata;

  logic               w_onehot;
  logic               w_rdy;
  logic               w_tmo;
  logic [31:0]        w_slot;

  assign w_onehot = (bus.sel != '0) &&
    ((bus.sel & (bus.sel - NUM_SLV'(1))) == '0);

  // r_sel is one-hot in ACCESS, so OR-ing the gated slots
  // picks exactly the selected peripheral.
  always_comb begin
    w_slot = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_sel[i]) w_slot = w_slot | bus.s_rdata[32*i +: 32];
    end
  end

  assign w_rdy = |(bus.s_ready & r_sel);
  assign w_tmo = (r_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.m_req) w_next = w_onehot ? ACCESS : RESP;
      end
      ACCESS: begin
        if (w_rdy || w_tmo) w_next = RESP;
      end
      RESP: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (bus.m_req) begin
            r_sel   <= bus.sel;
            r_we    <= bus.m_we;
            r_addr  <= bus.m_addr;
            r_wdata <= bus.m_wdata;
            r_wstrb <= bus.m_wstrb;
            r_err   <= !w_onehot;
            r_rdata <= ERR_RDATA;
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt + 16'd1;
          // Ready wins over a same-cycle timeout.
          if (w_rdy) begin
            r_err   <= 1'b0;
            r_rdata <= r_we ? '0 : w_slot;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_rdata <= ERR_RDATA;
          end
        end
        RESP: begin
          r_cnt <= '0;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.m_ready  = (r_state == IDLE);
  assign bus.m_rvalid = (r_state == RESP);
  assign bus.m_err    = (r_state == RESP) & r_err;
  assign bus.m_rdata  = (r_state == RESP) ? r_rdata : '0;
  assign bus.s_en     = (r_state == ACCESS) ? r_sel : '0;
  assign bus.s_we     = r_we;
  assign bus.s_addr   = r_addr;
  assign bus.s_wdata  = r_wdata;
  assign bus.s_wstrb  = r_wstrb;

`ifdef PERIPH_BRIDGE_ERR_LOG_EN
  logic w_q_onehot;

  // A one-hot latched select can only fail by timing out.
  assign w_q_onehot = (r_sel != '0) &&
    ((r_sel & (r_sel - NUM_SLV'(1))) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr  <= '0;
      err_cause <= '0;
      err_cnt   <= '0;
    end else if (err_clr) begin
      err_addr  <= '0;
      err_cause <= '0;
      err_cnt   <= '0;
    end else if (r_state == RESP && r_err) begin
      err_addr  <= r_addr;
      err_cause <= w_q_onehot ? 2'b10 : 2'b01;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
